// File: rtl/motor_cmd_pkg.sv
// Shared definitions for the motor command dispatcher.
//   parserStateT : 5-byte frame parser states (header then four payload bytes)
//   statusStateT : status transmitter states
//   FRAME_LEN    : bytes per command frame
//   RSV_W        : width of the reserved low field of the payload word
package motor_cmd_pkg;

  localparam int FRAME_LEN = 5;
  localparam int RSV_W     = 4;

  typedef enum logic [2:0] {HDR, B0, B1, B2, B3} parserStateT;
  typedef enum logic [1:0] {IDLE, SEND, GAP} statusStateT;

endpackage

// File: rtl/cmd_fifo.sv
// Single-channel command FIFO with simultaneous push and pop.
//   CLK_SE_AR : clock            rst_n    : async active-low reset
//   push/pop  : requests; pop is ignored when empty; push is accepted when
//               not full or when a pop happens in the same cycle
//   wrData    : entry to write   headData : entry at the read pointer
//   empty/full: occupancy flags
module cmd_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             CLK_SE_AR,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] headData,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign doPop    = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/motor_cmd_dispatcher.sv
// Motor command dispatcher: parses 5-byte frames from a byte stream into
// per-channel command FIFOs and optionally reports FIFO free space.
// Optional feature macro: DISPATCH_STATUS_TX_EN (status transmitter).
//   CLK_SE_AR, rst_n    : clock, async active-low reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   mc_div, mc_steps    : head divider / step count per channel (steps 0 if empty)
//   mc_valid, mc_active : head present per channel / controller busy per channel
//   tx_data, tx_start   : status byte and one-cycle send strobe
//   tx_busy             : transmitter busy
//   drop_cnt            : saturating count of rejected frames
// Handshake: a channel's head is consumed when mc_active rises (registered
// 0 -> 1) while mc_valid is high; a rise on an empty channel is ignored.
module motor_cmd_dispatcher
  import motor_cmd_pkg::*;
#(
  parameter int NCH     = 10,
  parameter int DEPTH   = 4,
  parameter int DIV_W   = 15,
  parameter int STEP_W  = 13,
  parameter int TIMEOUT = 24000,
  parameter int TX_GAP  = 8191
) (
  input  logic                    CLK_SE_AR,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [NCH*DIV_W-1:0]    mc_div,
  output logic [NCH*STEP_W-1:0]   mc_steps,
  output logic [NCH-1:0]          mc_valid,
  input  logic [NCH-1:0]          mc_active,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [7:0]              drop_cnt
);

  localparam int ENT_W = DIV_W + STEP_W;
  localparam int TW    = $clog2(TIMEOUT + 1);

  parserStateT          parserState;
  logic [3:0]           chan;
  logic [31:0]          word;
  logic [TW-1:0]        timer;
  logic                 pushReq;
  logic [31-RSV_W:0]    payload;
  logic [NCH-1:0]       actPrev;
  logic [NCH-1:0]       popVec;
  logic [NCH-1:0]       pushVec;
  logic [NCH-1:0]       fifoFull;
  logic [NCH-1:0]       fifoEmpty;
  logic [ENT_W-1:0]     headData [NCH];
  logic                 chanFull;
  logic                 chanPop;
  logic                 dropFrame;
  logic                 unusedBits;

  // Entry layout is {steps, divider}, taken straight above the reserved field.
  assign payload = word[31:RSV_W];
  assign popVec  = mc_active & ~actPrev & ~fifoEmpty;

  // Frame parser. The push is issued one cycle after B3 so the FIFO sees a
  // fully assembled word; the parser is already back in HDR by then.
  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      parserState <= HDR;
      chan        <= '0;
      word        <= '0;
      timer       <= '0;
      pushReq     <= 1'b0;
    end else begin
      pushReq <= 1'b0;
      if (rx_valid) begin
        timer <= '0;
        case (parserState)
          HDR: begin chan <= rx_data[3:0];   parserState <= B0; end
          B0:  begin word[7:0]   <= rx_data; parserState <= B1; end
          B1:  begin word[15:8]  <= rx_data; parserState <= B2; end
          B2:  begin word[23:16] <= rx_data; parserState <= B3; end
          B3:  begin
            word[31:24] <= rx_data;
            parserState <= HDR;
            pushReq     <= 1'b1;
          end
          default: parserState <= HDR;
        endcase
      end else if (parserState != HDR) begin
        // Stalled partial frame: abandon it silently after TIMEOUT idle clocks.
        if (int'(timer) >= TIMEOUT - 1) begin
          parserState <= HDR;
          timer       <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  always_comb begin
    chanFull = 1'b0;
    chanPop  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(chan) == c) begin
        chanFull = fifoFull[c];
        chanPop  = popVec[c];
      end
    end
    dropFrame = pushReq && ((int'(chan) >= NCH) || (chanFull && !chanPop));
  end

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      actPrev  <= '0;
      drop_cnt <= '0;
    end else begin
      actPrev <= mc_active;
      if (dropFrame && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : gCh
    assign pushVec[c] = pushReq && (int'(chan) == c);

    cmd_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) uFifo (
      .CLK_SE_AR (CLK_SE_AR),
      .rst_n     (rst_n),
      .push      (pushVec[c]),
      .pop       (popVec[c]),
      .wrData    (payload[ENT_W-1:0]),
      .headData  (headData[c]),
      .empty     (fifoEmpty[c]),
      .full      (fifoFull[c])
    );

    assign mc_valid[c]                    = ~fifoEmpty[c];
    assign mc_div[c*DIV_W +: DIV_W]       = headData[c][DIV_W-1:0];
    assign mc_steps[c*STEP_W +: STEP_W]   = fifoEmpty[c] ? '0 : headData[c][ENT_W-1:DIV_W];
  end

`ifdef DISPATCH_STATUS_TX_EN
  localparam int NPART = (NCH + 4) / 5;
  localparam int GW    = $clog2(TX_GAP + 1);

  statusStateT   statusState;
  logic [2:0]    part;
  logic [GW-1:0] gapCnt;
  logic [4:0]    freeBits;
  logic          anyFree;

  // Free-space bits for the five channels of the current part; channels
  // beyond NCH always read as free.
  always_comb begin
    freeBits = '1;
    for (int i = 0; i < 5; i++)
      for (int c = 0; c < NCH; c++)
        if (int'(part) * 5 + i == c) freeBits[i] = ~fifoFull[c];
  end

  assign anyFree = ~&fifoFull;

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      statusState <= IDLE;
      part        <= '0;
      gapCnt      <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      case (statusState)
        IDLE: begin
          if (anyFree && !tx_busy) begin
            tx_start    <= 1'b1;
            tx_data     <= {part, freeBits};
            statusState <= SEND;
          end
        end
        SEND: begin
          tx_start    <= 1'b0;
          part        <= (int'(part) >= NPART - 1) ? 3'd0 : part + 3'd1;
          gapCnt      <= '0;
          statusState <= GAP;
        end
        GAP: begin
          if (int'(gapCnt) >= TX_GAP - 1) statusState <= IDLE;
          else                            gapCnt      <= gapCnt + 1'b1;
        end
        default: statusState <= IDLE;
      endcase
    end
  end

  assign unusedBits = ^{word[RSV_W-1:0], payload};
`else
  assign tx_start   = 1'b0;
  assign tx_data    = 8'h00;
  assign unusedBits = ^{word[RSV_W-1:0], payload, tx_busy};
`endif

endmodule
